// File: rtl/write_back_unit.sv
// Y86 write-back stage: two registered register-file write ports and a RUN/HALT status FSM.
// Optional retire counter is enabled with `define WB_RETIRE_CNT_EN.
module write_back_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 4,
    parameter int RSP_IDX   = 4,
    parameter int RNONE_IDX = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [REG_AW-1:0] rA,
    input  logic [REG_AW-1:0] rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [1:0]        stat_in,
    input  logic              restart,
    output logic              reg_write1,
    output logic [REG_AW-1:0] reg_reg1,
    output logic [DATA_W-1:0] reg_value1,
    output logic              reg_write2,
    output logic [REG_AW-1:0] reg_reg2,
    output logic [DATA_W-1:0] reg_value2,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]       retire_count,
`endif
    output logic              halted,
    output logic [1:0]        cpu_stat
);

    typedef enum logic [0:0] {RUN, HALT} state_e;
    typedef enum logic [1:0] {STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS} stat_e;

    localparam logic [REG_AW-1:0] RSP   = REG_AW'(RSP_IDX);
    localparam logic [REG_AW-1:0] RNONE = REG_AW'(RNONE_IDX);

    state_e            state, nextState;
    stat_e             statReg, statNext;
    logic              accept, haltReq, retire;
    logic              wr1Next, wr2Next;
    logic [REG_AW-1:0] idx1Next, idx2Next;
    logic [DATA_W-1:0] val1Next, val2Next;

    assign in_ready = (state == RUN);
    assign halted   = (state == HALT);
    assign accept   = in_valid && (state == RUN);
    assign cpu_stat = statReg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (state == RUN && haltReq)      nextState = HALT;
        else if (state == HALT && restart) nextState = RUN;
    end

    always_comb begin
        wr1Next  = 1'b0;
        wr2Next  = 1'b0;
        idx1Next = reg_reg1;
        idx2Next = reg_reg2;
        val1Next = reg_value1;
        val2Next = reg_value2;
        statNext = statReg;
        haltReq  = 1'b0;
        retire   = 1'b0;
        if (accept) begin
            if (stat_in != 2'(STAT_AOK)) begin
                haltReq  = 1'b1;
                statNext = stat_e'(stat_in);
            end else begin
                case (icode)
                    4'h0: begin haltReq = 1'b1; statNext = STAT_HLT; end
                    4'h2: begin wr1Next = cnd;  idx1Next = rB;  val1Next = valE; end
                    4'h3, 4'h6:
                          begin wr1Next = 1'b1; idx1Next = rB;  val1Next = valE; end
                    4'h5: begin wr1Next = 1'b1; idx1Next = rA;  val1Next = valM; end
                    4'h8, 4'h9, 4'hA:
                          begin wr1Next = 1'b1; idx1Next = RSP; val1Next = valE; end
                    4'hB: begin
                        wr1Next = 1'b1; idx1Next = RSP; val1Next = valE;
                        wr2Next = 1'b1; idx2Next = rA;  val2Next = valM;
                    end
                    4'hC, 4'hD, 4'hE, 4'hF:
                          begin haltReq = 1'b1; statNext = STAT_INS; end
                    default: ;
                endcase
                retire = (icode >= 4'h1) && (icode <= 4'hB);
            end
        end else if (state == HALT && restart) begin
            statNext = STAT_AOK;
        end
        if (idx1Next == RNONE) wr1Next = 1'b0;
        if (idx2Next == RNONE) wr2Next = 1'b0;
        // popl %esp: the loaded value wins over the stack-pointer update
        if (wr1Next && wr2Next && idx1Next == idx2Next) wr1Next = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_write1 <= 1'b0;
            reg_reg1   <= '0;
            reg_value1 <= '0;
            reg_write2 <= 1'b0;
            reg_reg2   <= '0;
            reg_value2 <= '0;
            statReg    <= STAT_AOK;
        end else begin
            reg_write1 <= wr1Next;
            reg_reg1   <= idx1Next;
            reg_value1 <= val1Next;
            reg_write2 <= wr2Next;
            reg_reg2   <= idx2Next;
            reg_value2 <= val2Next;
            statReg    <= statNext;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      retire_count <= '0;
        else if (state == HALT && restart) retire_count <= '0;
        else if (retire)                   retire_count <= retire_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard bench for write_back_unit: each driven instruction pushes its expected outputs,
// which are popped and compared one cycle later.
module tb_write_back_unit;

    typedef struct {
        logic        w1;
        logic [3:0]  r1;
        logic [31:0] v1;
        logic        w2;
        logic [3:0]  r2;
        logic [31:0] v2;
        logic        halt;
        logic [1:0]  stat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = '0;
    logic        cnd = 1'b0;
    logic [3:0]  rA = '0;
    logic [3:0]  rB = '0;
    logic [31:0] valE = '0;
    logic [31:0] valM = '0;
    logic [1:0]  stat_in = '0;
    logic        restart = 1'b0;
    logic        reg_write1, reg_write2, halted;
    logic [3:0]  reg_reg1, reg_reg2;
    logic [31:0] reg_value1, reg_value2;
    logic [1:0]  cpu_stat;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
    logic [31:0] expCount = '0;
`endif

    int   nCompared = 0;
    int   nMismatched = 0;
    exp_t sb[$];
    logic expHalted = 1'b0;

    write_back_unit #(.DATA_W(32), .REG_AW(4), .RSP_IDX(4), .RNONE_IDX(15)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
        .stat_in(stat_in), .restart(restart),
        .reg_write1(reg_write1), .reg_reg1(reg_reg1), .reg_value1(reg_value1),
        .reg_write2(reg_write2), .reg_reg2(reg_reg2), .reg_value2(reg_value2),
`ifdef WB_RETIRE_CNT_EN
        .retire_count(retire_count),
`endif
        .halted(halted), .cpu_stat(cpu_stat)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic w1, input logic [3:0] r1, input logic [31:0] v1,
                                input logic w2, input logic [3:0] r2, input logic [31:0] v2,
                                input logic halt, input logic [1:0] stat);
        exp_t e;
        e.w1 = w1; e.r1 = r1; e.v1 = v1;
        e.w2 = w2; e.r2 = r2; e.v2 = v2;
        e.halt = halt; e.stat = stat;
        return e;
    endfunction

    task automatic step(input string tag, input logic v, input logic [3:0] ic, input logic c,
                        input logic [3:0] a, input logic [3:0] b, input logic [31:0] e,
                        input logic [31:0] m, input logic [1:0] st, input logic rs, input exp_t ex);
        exp_t got;
        @(negedge clock);
        in_valid = v; icode = ic; cnd = c; rA = a; rB = b;
        valE = e; valM = m; stat_in = st; restart = rs;
        checkVal({tag, ".ready"}, 64'(in_ready), 64'(!expHalted));
`ifdef WB_RETIRE_CNT_EN
        if (rs && expHalted) expCount = '0;
        else if (v && !expHalted && st == 2'd0 && ic >= 4'h1 && ic <= 4'hB) expCount++;
`endif
        sb.push_back(ex);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        checkVal({tag, ".w1"},   64'(reg_write1), 64'(got.w1));
        checkVal({tag, ".w2"},   64'(reg_write2), 64'(got.w2));
        if (got.w1) begin
            checkVal({tag, ".r1"}, 64'(reg_reg1),   64'(got.r1));
            checkVal({tag, ".v1"}, 64'(reg_value1), 64'(got.v1));
        end
        if (got.w2) begin
            checkVal({tag, ".r2"}, 64'(reg_reg2),   64'(got.r2));
            checkVal({tag, ".v2"}, 64'(reg_value2), 64'(got.v2));
        end
        checkVal({tag, ".halted"}, 64'(halted),   64'(got.halt));
        checkVal({tag, ".stat"},   64'(cpu_stat), 64'(got.stat));
        expHalted = got.halt;
`ifdef WB_RETIRE_CNT_EN
        checkVal({tag, ".count"}, 64'(retire_count), 64'(expCount));
`endif
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        checkVal("rst.w1",    64'(reg_write1), 64'd0);
        checkVal("rst.w2",    64'(reg_write2), 64'd0);
        checkVal("rst.r1",    64'(reg_reg1),   64'd0);
        checkVal("rst.v1",    64'(reg_value1), 64'd0);
        checkVal("rst.halt",  64'(halted),     64'd0);
        checkVal("rst.stat",  64'(cpu_stat),   64'd0);
        checkVal("rst.ready", 64'(in_ready),   64'd1);
        @(negedge clock);
        reset_n = 1'b1;

        step("irmovl", 1, 4'h3, 0, 4'hF, 4'd2, 32'h1234, 32'h0, 2'd0, 0,
             mk(1, 4'd2, 32'h1234, 0, 4'd0, 32'd0, 0, 2'd0));
        step("idle", 0, 4'h3, 0, 4'hF, 4'd7, 32'h9999, 32'h0, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 2'd0));
        checkVal("hold.r1", 64'(reg_reg1),   64'd2);
        checkVal("hold.v1", 64'(reg_value1), 64'h1234);
        step("cmovNT", 1, 4'h2, 0, 4'hF, 4'd5, 32'h55, 32'h0, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 2'd0));
        step("cmovT", 1, 4'h2, 1, 4'hF, 4'd3, 32'h7, 32'h0, 2'd0, 0,
             mk(1, 4'd3, 32'h7, 0, 4'd0, 32'd0, 0, 2'd0));
        step("popl", 1, 4'hB, 0, 4'd0, 4'hF, 32'h100, 32'hAB, 2'd0, 0,
             mk(1, 4'd4, 32'h100, 1, 4'd0, 32'hAB, 0, 2'd0));
        step("poplEsp", 1, 4'hB, 0, 4'd4, 4'hF, 32'h104, 32'hAB, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 1, 4'd4, 32'hAB, 0, 2'd0));
        step("rnone", 1, 4'h6, 0, 4'd1, 4'hF, 32'h77, 32'h0, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 2'd0));
        step("mrmovl", 1, 4'h5, 0, 4'd6, 4'd1, 32'h11, 32'h55, 2'd0, 0,
             mk(1, 4'd6, 32'h55, 0, 4'd0, 32'd0, 0, 2'd0));
        step("call", 1, 4'h8, 0, 4'hF, 4'hF, 32'hFC, 32'h0, 2'd0, 0,
             mk(1, 4'd4, 32'hFC, 0, 4'd0, 32'd0, 0, 2'd0));
        step("nop", 1, 4'h1, 0, 4'd2, 4'd2, 32'h1, 32'h1, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 2'd0));
        step("halt", 1, 4'h0, 0, 4'd2, 4'd2, 32'h1, 32'h1, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 2'd1));
        step("inHalt", 1, 4'h3, 0, 4'hF, 4'd2, 32'h5, 32'h0, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 2'd1));
        step("restart", 0, 4'h3, 0, 4'hF, 4'd2, 32'h5, 32'h0, 2'd0, 1,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 2'd0));
        step("rstInRun", 1, 4'h3, 0, 4'hF, 4'd1, 32'hBEEF, 32'h0, 2'd0, 1,
             mk(1, 4'd1, 32'hBEEF, 0, 4'd0, 32'd0, 0, 2'd0));
        step("adr", 1, 4'h5, 0, 4'd3, 4'd1, 32'h0, 32'h66, 2'd2, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 2'd2));
        step("restart2", 0, 4'h0, 0, 4'd0, 4'd0, 32'h0, 32'h0, 2'd0, 1,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 2'd0));
        step("ins", 1, 4'hE, 0, 4'd3, 4'd3, 32'h1, 32'h1, 2'd0, 0,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 2'd3));
        step("restart3", 0, 4'h0, 0, 4'd0, 4'd0, 32'h0, 32'h0, 2'd0, 1,
             mk(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 2'd0));
        step("pushl", 1, 4'hA, 0, 4'd1, 4'hF, 32'hF8, 32'h0, 2'd0, 0,
             mk(1, 4'd4, 32'hF8, 0, 4'd0, 32'd0, 0, 2'd0));

        #1;
        reset_n = 1'b0;
        #1;
        checkVal("async.w1",   64'(reg_write1), 64'd0);
        checkVal("async.r1",   64'(reg_reg1),   64'd0);
        checkVal("async.v1",   64'(reg_value1), 64'd0);
        checkVal("async.stat", 64'(cpu_stat),   64'd0);
        checkVal("async.halt", 64'(halted),     64'd0);
`ifdef WB_RETIRE_CNT_EN
        checkVal("async.count", 64'(retire_count), 64'd0);
`endif
        checkVal("sb.empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/write_back_unit.md
Name: write_back_unit

Overview:
- Parametrised Y86 write-back stage and successor to the fixed 32-bit, always-writing write-back.
- Accepts one retiring instruction per cycle through a valid/ready handshake.
- Produces two registered register-file write ports and tracks processor status in a RUN/HALT state machine.
- Adds conditional-move gating, RNONE suppression, popl same-register priority, halt/restart and exception latching.
- Sits between the memory stage and the register file.

Parameters:
- DATA_W, 32: width of valE, valM and the write values.
- REG_AW, 4: register index width.
- RSP_IDX, 4: index of %esp, the stack pointer written by call/ret/pushl/popl.
- RNONE_IDX, 15: "no register" index; a write to this index is suppressed.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream instruction valid.
- in_ready, output, 1: stage can accept; combinational, equals (state==RUN).
- icode, input, 4: instruction code.
- cnd, input, 1: condition result; used only for icode 2.
- rA, input, REG_AW: source/destination field A.
- rB, input, REG_AW: destination field B.
- valE, input, DATA_W: ALU result.
- valM, input, DATA_W: memory read result.
- stat_in, input, 2: upstream status; 0=AOK, 1=HLT, 2=ADR, 3=INS.
- restart, input, 1: single-cycle pulse; leaves HALT.
- reg_write1, output, 1: port-1 write strobe.
- reg_reg1, output, REG_AW: port-1 index.
- reg_value1, output, DATA_W: port-1 data.
- reg_write2, output, 1: port-2 write strobe.
- reg_reg2, output, REG_AW: port-2 index.
- reg_value2, output, DATA_W: port-2 data.
- halted, output, 1: high while in HALT.
- cpu_stat, output, 2: latched processor status.

Behaviour:
- Reset (reset_n low, asynchronous): state=RUN, all strobes 0, reg_reg*/reg_value* 0, cpu_stat=AOK, halted=0. Reset mid-instruction discards it.
- Accept = in_valid && in_ready. All outputs are registered, with 1-cycle latency from accept.
- Strobes are single-cycle pulses. With no accept in a cycle, both strobes are 0 the next cycle; index and value outputs hold.
- Decode in RUN, on accept with stat_in=AOK:
  - icode 0 (halt): no writes; next state HALT; cpu_stat<=HLT.
  - icode 1, 4, 7: no writes.
  - icode 2: port1 = rB <- valE, only if cnd=1.
  - icode 3, 6: port1 = rB <- valE.
  - icode 5: port1 = rA <- valM.
  - icode 8, 9, A: port1 = RSP_IDX <- valE.
  - icode B: port1 = RSP_IDX <- valE and port2 = rA <- valM.
  - icode C–F: no writes; HALT; cpu_stat<=INS.
- Suppression:
  - Any port whose index equals RNONE_IDX has its strobe forced to 0.
  - If both strobes would assert with equal indices (popl %esp), port1 is suppressed and port2 (valM) alone writes.
- Accept with stat_in≠AOK: no writes; HALT; cpu_stat<=stat_in. stat_in takes precedence over icode decode.
- HALT state:
  - in_ready=0 and halted=1; in_valid is ignored.
  - A restart pulse returns the state to RUN and sets cpu_stat<=AOK in the next cycle.
  - restart in RUN has no effect.
- Entering HALT and restart in the same cycle is impossible: restart is only sampled in HALT.
- Strobes produced by the instruction that causes the halt are 0.

Optional Feature:
- WB_RETIRE_CNT_EN defined:
  - Adds output retire_count, 32 bits, reset 0.
  - Increments by 1 on every accepted instruction with stat_in=AOK and icode 1–B; the halt instruction is not counted.
  - Wraps 0xFFFFFFFF->0.
  - Cleared by restart.
- WB_RETIRE_CNT_EN undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- irmovl: icode=3, rB=2, valE=0x1234, stat_in=AOK -> next cycle reg_write1=1, reg_reg1=2, reg_value1=0x1234, reg_write2=0; the strobe drops the cycle after that.
- cmov not taken: icode=2, cnd=0 -> reg_write1=0. Same instruction with cnd=1, rB=3, valE=7 -> write r3=7.
- popl: icode=B, rA=0, valE=0x100, valM=0xAB -> port1 r4=0x100 and port2 r0=0xAB. With rA=4 instead -> reg_write1=0, reg_write2=1 writing r4=0xAB.
- RNONE: icode=6, rB=15 -> no strobes.
- Halt: icode=0 -> halted=1, cpu_stat=HLT, in_ready=0; further in_valid produces no writes. A restart pulse -> RUN, cpu_stat=AOK, in_ready=1.
- Exceptions:
  - stat_in=ADR with icode=5 -> no write, cpu_stat=2.
  - icode=0xE with stat_in=AOK -> cpu_stat=INS.
  - Asserting reset_n low mid-stream clears all outputs immediately.
